// File: rtl/instruction_fetch_queue.sv
// Block fetcher feeding a circular instruction queue drained one entry per cycle to the decoder.
// Optional performance counters are compiled in when IFQ_PERF_CTR_EN is defined.
module instruction_fetch_queue #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0000_0060,
  localparam int unsigned READ_WIDTH = 32 * FETCH_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fls,
  input  logic [31:0]                    flush_pc_i,
  input  logic [READ_WIDTH-1:0]          mem_rdata_i,
  input  logic                           mem_resp_i,
  output logic [31:0]                    mem_address_o,
  output logic                           mem_read_o,
  output logic                           inst_valid_o,
  output logic [31:0]                    inst_o,
  output logic [31:0]                    inst_pc_o,
  input  logic                           decoder_rdy_i,
  output logic [$clog2(QUEUE_DEPTH):0]   count_o
`ifdef IFQ_PERF_CTR_EN
  ,
  output logic [31:0]                    fetch_cnt_o,
  output logic [31:0]                    discard_cnt_o
`endif
);

  localparam int unsigned OFF = $clog2(FETCH_WIDTH) + 2;
  localparam int unsigned PW  = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] BLOCK_MASK = ~((32'd1 << OFF) - 32'd1);

  typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

  state_e        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   mem_address;
  logic          mem_read;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   inst_mem [QUEUE_DEPTH];
  logic [31:0]   pc_mem   [QUEUE_DEPTH];

  logic          deq;
  logic          accept;
  logic [31:0]   fetch_k;
  logic [31:0]   count_after;
  logic          issue_ok;
  logic [CW-1:0] enq_n;

  // Handshake, word offset inside the block, and room check against the post-dequeue count.
  always_comb begin
    deq         = (count != '0) && decoder_rdy_i;
    accept      = (state == StReq) && mem_resp_i && !fls;
    fetch_k     = (fetch_pc >> 2) & (FETCH_WIDTH - 1);
    count_after = 32'(count) - 32'(deq);
    issue_ok    = (32'(QUEUE_DEPTH) - count_after) >= (32'(FETCH_WIDTH) - fetch_k);
    enq_n       = accept ? CW'(32'(FETCH_WIDTH) - fetch_k) : '0;
  end

  // Queue storage: words k..FETCH_WIDTH-1 of an accepted block land at consecutive slots.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        if (i >= fetch_k) begin
          inst_mem[tail + PW'(i - fetch_k)] <= mem_rdata_i[32*i +: 32];
          pc_mem[tail + PW'(i - fetch_k)]   <= mem_address + 32'(4 * i);
        end
      end
    end
  end

  // Fetch FSM, queue pointers and occupancy; flush wins over response and dequeue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      fetch_pc    <= RESET_PC;
      mem_address <= '0;
      mem_read    <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      if (fls) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        fetch_pc <= flush_pc_i;
      end else begin
        head  <= head + PW'(deq);
        tail  <= tail + enq_n[PW-1:0];
        count <= count + enq_n - CW'(deq);
      end

      case (state)
        StIdle: begin
          if (!fls && issue_ok) begin
            state       <= StReq;
            mem_read    <= 1'b1;
            mem_address <= fetch_pc & BLOCK_MASK;
          end
        end
        StReq: begin
          if (mem_resp_i) begin
            state    <= StIdle;
            mem_read <= 1'b0;
            if (!fls) fetch_pc <= mem_address + 32'(4 * FETCH_WIDTH);
          end else if (fls) begin
            // Request stays outstanding; its data must be swallowed.
            state <= StDiscard;
          end
        end
        StDiscard: begin
          if (mem_resp_i) begin
            state    <= StIdle;
            mem_read <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Head of queue and memory request outputs.
  always_comb begin
    inst_valid_o  = (count != '0);
    inst_o        = inst_mem[head];
    inst_pc_o     = pc_mem[head];
    count_o       = count;
    mem_address_o = mem_address;
    mem_read_o    = mem_read;
  end

`ifdef IFQ_PERF_CTR_EN
  logic [31:0] fetch_cnt;
  logic [31:0] discard_cnt;

  // Accepted and dropped response counters; untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt   <= '0;
      discard_cnt <= '0;
    end else begin
      if (accept) fetch_cnt <= fetch_cnt + 32'd1;
      if (mem_resp_i && ((state == StReq && fls) || state == StDiscard)) begin
        discard_cnt <= discard_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt_o   = fetch_cnt;
  assign discard_cnt_o = discard_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomized scoreboard bench for instruction_fetch_queue with a queue-based reference model.
module tb_instruction_fetch_queue;

  localparam int unsigned FW = 2;
  localparam int unsigned QD = 8;
  localparam int unsigned RW = 32 * FW;
  localparam int unsigned OFF = $clog2(FW) + 2;
  localparam logic [31:0] BLK_MASK = ~((32'd1 << OFF) - 32'd1);

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  fls;
  logic [31:0]           flush_pc_i;
  logic [RW-1:0]         mem_rdata_i;
  logic                  mem_resp_i;
  logic [31:0]           mem_address_o;
  logic                  mem_read_o;
  logic                  inst_valid_o;
  logic [31:0]           inst_o;
  logic [31:0]           inst_pc_o;
  logic                  decoder_rdy_i;
  logic [$clog2(QD):0]   count_o;
`ifdef IFQ_PERF_CTR_EN
  logic [31:0]           fetch_cnt;
  logic [31:0]           discard_cnt;
`endif

  instruction_fetch_queue #(
    .FETCH_WIDTH (FW),
    .QUEUE_DEPTH (QD),
    .RESET_PC    (32'h0000_0060)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fls           (fls),
    .flush_pc_i    (flush_pc_i),
    .mem_rdata_i   (mem_rdata_i),
    .mem_resp_i    (mem_resp_i),
    .mem_address_o (mem_address_o),
    .mem_read_o    (mem_read_o),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .decoder_rdy_i (decoder_rdy_i),
    .count_o       (count_o)
`ifdef IFQ_PERF_CTR_EN
    ,
    .fetch_cnt_o   (fetch_cnt),
    .discard_cnt_o (discard_cnt)
`endif
  );

  always #5 clk = ~clk;

  int     nvec = 0;
  int     nerr = 0;
  int     popped = 0;
  bit     checking = 1'b0;
  entry_t exp_q[$];

  // Reference model state
  logic [31:0] model_pc;
  logic [31:0] held_addr;
  logic [31:0] fetch_m;
  logic [31:0] discard_m;
  logic [RW-1:0] last_rdata;
  logic [31:0] last_flush_pc;
  bit   prev_read, last_fls, last_resp, tainted, exp_issue;
  int   k, lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares occupancy and pops/compares the head on every handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        check("count", 32'(count_o), 32'(exp_q.size()));
        check("valid", 32'(inst_valid_o), 32'(exp_q.size() != 0));
        if (inst_valid_o && decoder_rdy_i && exp_q.size() != 0) begin
          check("inst", inst_o, exp_q[0].inst);
          check("inst_pc", inst_pc_o, exp_q[0].pc);
          void'(exp_q.pop_front());
          popped++;
        end
      end
    end
  end

  // Driver, memory model and scoreboard producer.
  initial begin
    rst = 1'b1;
    fls = 1'b0;
    flush_pc_i = '0;
    mem_rdata_i = '0;
    mem_resp_i = 1'b0;
    decoder_rdy_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_read", 32'(mem_read_o), 32'd0);
    check("rst_addr", mem_address_o, 32'd0);
    rst = 1'b0;
    model_pc = 32'h60;
    held_addr = '0;
    fetch_m = '0;
    discard_m = '0;
    prev_read = 1'b0;
    last_fls = 1'b0;
    last_resp = 1'b0;
    tainted = 1'b0;
    lat = 0;
    checking = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      // Request issue rule: idle, no flush, enough free slots after this cycle's dequeue.
      if (!prev_read) begin
        k = int'((model_pc >> 2) & (FW - 1));
        exp_issue = !last_fls && ((int'(QD) - exp_q.size()) >= (int'(FW) - k));
        check("issue", 32'(mem_read_o), 32'(exp_issue));
        if (exp_issue && mem_read_o) check("req_addr", mem_address_o, model_pc & BLK_MASK);
      end
      // Effects of the previous cycle's response and flush.
      if (last_resp) begin
        if (!tainted && !last_fls) begin
          k = int'((model_pc >> 2) & (FW - 1));
          for (int w = k; w < int'(FW); w++) begin
            exp_q.push_back('{inst: last_rdata[32*w +: 32],
                              pc: (model_pc & BLK_MASK) + 32'(4 * w)});
          end
          model_pc = (model_pc & BLK_MASK) + 32'(4 * FW);
          fetch_m++;
        end else begin
          discard_m++;
        end
      end
      if (last_fls) begin
        exp_q.delete();
        model_pc = last_flush_pc;
        if (prev_read && !last_resp) tainted = 1'b1;
      end
      // Request lifetime: held until response, dropped after it.
      if (!prev_read && mem_read_o) begin
        tainted = 1'b0;
        held_addr = mem_address_o;
        lat = (i < 400) ? 0 : int'($urandom_range(0, 4));
      end else if (prev_read && !last_resp) begin
        check("read_held", 32'(mem_read_o), 32'd1);
        check("addr_held", mem_address_o, held_addr);
      end else if (prev_read && last_resp) begin
        check("read_drop", 32'(mem_read_o), 32'd0);
      end
`ifdef IFQ_PERF_CTR_EN
      check("fetch_cnt", fetch_cnt, fetch_m);
      check("discard_cnt", discard_cnt, discard_m);
`endif
      if (i == 1500) begin
        check("full_count", 32'(count_o), QD);
        check("full_no_read", 32'(mem_read_o), 32'd0);
      end

      // New inputs for this cycle.
      mem_resp_i = 1'b0;
      if (mem_read_o) begin
        if (lat == 0) mem_resp_i = 1'b1;
        else lat--;
      end
      for (int w = 0; w < int'(FW); w++) mem_rdata_i[32*w +: 32] = $urandom;
      if (i < 400) decoder_rdy_i = 1'b1;
      else if (i >= 1400 && i < 1500) decoder_rdy_i = 1'b0;
      else if (i >= 1500 && i < 1510) decoder_rdy_i = (i == 1500);
      else decoder_rdy_i = ($urandom_range(0, 9) < 7);
      fls = 1'b0;
      if ((i >= 400 && i < 1400) || i >= 1510) begin
        fls = (mem_resp_i && $urandom_range(0, 4) == 0) || ($urandom_range(0, 29) == 0);
      end
      flush_pc_i = 32'h100 + {22'd0, 8'($urandom), 2'($urandom)};
      if (i == 2000) begin
        fls = 1'b1;
        flush_pc_i = 32'h104;
      end
      prev_read = mem_read_o;
      last_fls = fls;
      last_resp = mem_resp_i;
      last_rdata = mem_rdata_i;
      last_flush_pc = flush_pc_i;
    end

    @(negedge clk);
    checking = 1'b0;
    check("throughput", 32'(popped > 500), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
Parametrised successor to the single-instruction fetcher. Fetches an aligned block of FETCH_WIDTH instructions per memory read and buffers them with their PCs in a circular queue of QUEUE_DEPTH entries. Drains the queue to the decoder one instruction per cycle over a valid/ready handshake. Sits between the I-cache port and the decoder; redirect (branch/flush) arrives on fls with a new PC.

Parameters:
FETCH_WIDTH, 2, instructions per memory read; power of 2, 1..8
QUEUE_DEPTH, 8, queue entries; power of 2, >= FETCH_WIDTH
RESET_PC, 32'h0000_0060, fetch PC after reset
READ_WIDTH, 32*FETCH_WIDTH, memory read data width (derived; not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
fls  in  1  flush/redirect; sampled on clock edge
flush_pc_i  in  32  new fetch PC, valid when fls=1
mem_rdata_i  in  READ_WIDTH  block data; word i = bits [32i+31:32i]
mem_resp_i  in  1  memory response, data valid this cycle
mem_address_o  out  32  block-aligned read address
mem_read_o  out  1  read request; held until mem_resp_i
inst_valid_o  out  1  queue head valid
inst_o  out  32  queue head instruction
inst_pc_o  out  32  queue head PC
decoder_rdy_i  in  1  decoder accepts head this cycle
count_o  out  $clog2(QUEUE_DEPTH)+1  occupied entries

Behaviour:
- OFF = $clog2(FETCH_WIDTH)+2. Block address = fetch_pc with bits [OFF-1:0] zeroed; word index k = fetch_pc[OFF-1:2]; fetch_pc[1:0] ignored.
- Reset: fetch_pc=RESET_PC, queue empty, count_o=0, inst_valid_o=0, mem_read_o=0, mem_address_o=0, state IDLE.
- States: IDLE, REQ, DISCARD.
- IDLE -> REQ when free slots (QUEUE_DEPTH-count_o) >= FETCH_WIDTH-k, evaluated with the count after this cycle's dequeue. On entry, mem_address_o registers the block address.
- REQ: mem_read_o=1, mem_address_o stable. On mem_resp_i, enqueue words k..FETCH_WIDTH-1 in order (PC = block address + 4*i), set fetch_pc = block address + 4*FETCH_WIDTH, go to IDLE. Enqueued entries become visible the next cycle (1-cycle resp-to-valid latency).
- DISCARD: entered when fls=1 while in REQ without mem_resp_i that cycle. mem_read_o stays 1 and mem_address_o is unchanged until mem_resp_i; the data is dropped; then go to IDLE. A request is never abandoned.
- Dequeue: when inst_valid_o && decoder_rdy_i, head advances. Simultaneous enqueue and dequeue is allowed; count_o = count + enq_n - deq.
- Pointers wrap modulo QUEUE_DEPTH. Full queue blocks new requests only; a request in flight always has room (checked at issue).
- fls (priority over mem_resp_i and dequeue): queue emptied, count_o=0, fetch_pc=flush_pc_i. State -> DISCARD if in REQ without resp, else IDLE. A response arriving the same cycle as fls is dropped. inst_valid_o=0 the cycle after fls.
- rst has priority over fls. rst during REQ or DISCARD returns to IDLE; the memory side is reset together with this block.
- inst_o and inst_pc_o are don't-care when inst_valid_o=0.

Optional Feature:
IFQ_PERF_CTR_EN: when defined, adds outputs fetch_cnt_o[31:0] and discard_cnt_o[31:0].
- fetch_cnt_o increments on each accepted (non-discarded) mem_resp_i.
- discard_cnt_o increments on each response dropped by DISCARD or by a same-cycle fls.
- Both counters reset to 0 on rst, wrap at 2^32, and are unaffected by fls.
When not defined, these ports and their logic are absent.

Test Plan:
- FETCH_WIDTH=2, reset, decoder_rdy_i=1, memory 1-cycle resp -> mem_address_o=0x60; inst_pc_o sequence 0x60, 0x64, 0x68, 0x6C...; no gaps once steady.
- fls with flush_pc_i=0x104 (k=1) -> mem_address_o=0x100; only word 1 enqueued (inst_pc_o=0x104); next fetch at 0x108.
- decoder_rdy_i=0, QUEUE_DEPTH=8, FETCH_WIDTH=2 -> count_o saturates at 8; mem_read_o stays 0 while full; one dequeue -> still no request until 2 slots are free.
- fls asserted 2 cycles into a 5-cycle REQ -> mem_read_o held through resp; data dropped; next request uses flush_pc_i; no stale inst_valid_o.
- fls and mem_resp_i in the same cycle with count_o=3 -> count_o=0 next cycle, nothing enqueued; discard_cnt_o +1 when IFQ_PERF_CTR_EN is defined.
- Simultaneous enqueue of 2 and dequeue of 1 with write pointer at entry 7 -> pointer wraps to 1; count_o increases by 1; FIFO order preserved.
